// File: rtl/pmod_enc_pkg.sv
// Shared constants and next-count arithmetic for the PmodENC encoder bank.
// Arithmetic uses a fixed 33-bit working width, so any counter width up to 32 bits works.
package pmod_enc_pkg;

  localparam int MODE_SATURATE = 0;
  localparam int MODE_WRAP     = 1;

  localparam int IN_A   = 0;
  localparam int IN_B   = 1;
  localparam int IN_BTN = 2;

  localparam int CALC_W = 33;
  typedef logic [CALC_W-1:0] calc_t;

  // The result is always in 0..max-1 when count is in range and step < max.
  function automatic calc_t next_count(input calc_t count, input logic up,
                                       input calc_t step, input calc_t max,
                                       input logic wrap);
    calc_t res;
    if (up) begin
      if (count + step <= max - calc_t'(1)) res = count + step;
      else if (wrap)                        res = count + step - max;
      else                                  res = max - calc_t'(1);
    end else begin
      if (count >= step) res = count - step;
      else if (wrap)     res = count + max - step;
      else               res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/enc_channel.sv
// One encoder channel: synchronizers, three run-length filters, edge detect
// and the bounded position counter with its change/direction strobes.
module enc_channel
  import pmod_enc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX      = 160,
  parameter int FACTOR   = 0,
  parameter int WRAP     = 0,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             btn,
  output logic [WIDTH-1:0] count,
  output logic             changed,
  output logic             dir
);

  localparam int    RUN_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam calc_t STEP  = calc_t'(1) << FACTOR;
  localparam calc_t MAX_V = calc_t'(MAX);

  logic [2:0]       raw, sync1, sync2, level, level_d;
  logic [RUN_W-1:0] run [3];
  logic             rise_a, rise_btn, step_up;
  logic [WIDTH-1:0] next_cnt;

  assign raw      = {btn, b, a};
  assign rise_a   = level[IN_A] & ~level_d[IN_A];
  assign rise_btn = level[IN_BTN] & ~level_d[IN_BTN];
  assign step_up  = ~level[IN_B];
  assign next_cnt = WIDTH'(next_count(calc_t'(count), step_up, STEP, MAX_V,
                                      WRAP == MODE_WRAP));

  // NOTE: every register here, including the filter run counters, is reset so
  // no half-filtered level or pending edge can survive a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 3; i++) run[i] <= '0;
      count   <= '0;
      changed <= 1'b0;
      dir     <= 1'b1;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      changed <= 1'b0;

      // A new level is accepted only after DEBOUNCE consecutive differing samples.
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          run[i] <= '0;
        end else if (run[i] == RUN_W'(DEBOUNCE - 1)) begin
          level[i] <= sync2[i];
          run[i]   <= '0;
        end else begin
          run[i] <= run[i] + RUN_W'(1);
        end
      end

      // Button clear has priority over a detent in the same cycle.
      if (rise_btn) begin
        count   <= '0;
        changed <= 1'b1;
      end else if (rise_a) begin
        dir <= step_up;
        if (next_cnt != count) begin
          count   <= next_cnt;
          changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pmod_enc_array.sv
// Bank of independent quadrature encoder counters; the top only slices the
// input buses and concatenates per-channel results.
module pmod_enc_array
  import pmod_enc_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int MAX      = 160,
  parameter int FACTOR   = 0,
  parameter int WRAP     = MODE_SATURATE,
  parameter int DEBOUNCE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       enc_a,
  input  logic [CHANNELS-1:0]       enc_b,
  input  logic [CHANNELS-1:0]       enc_btn,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS-1:0]       dir
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    enc_channel #(
      .WIDTH    (WIDTH),
      .MAX      (MAX),
      .FACTOR   (FACTOR),
      .WRAP     (WRAP),
      .DEBOUNCE (DEBOUNCE)
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .a       (enc_a[i]),
      .b       (enc_b[i]),
      .btn     (enc_btn[i]),
      .count   (count[i*WIDTH +: WIDTH]),
      .changed (changed[i]),
      .dir     (dir[i])
    );
  end

endmodule

// File: tb/tb_pmod_enc_array.sv
// Scoreboard bench for pmod_enc_array: a saturating instance (MAX=160, step 1)
// and a wrapping instance (MAX=256, step 2), both with DEBOUNCE=4.
module tb_pmod_enc_array;

  typedef struct {
    int ch;
    int cnt;
    bit dir;
    int due;
  } exp_t;

  localparam int LAT = 7;

  logic        clk = 1'b0;
  logic        rst_s = 1'b1, rst_w = 1'b1;
  logic [2:0]  a_s = '0, b_s = '0, btn_s = '0;
  logic [2:0]  a_w = '0, b_w = '0, btn_w = '0;
  logic [23:0] cnt_s, cnt_w;
  logic [2:0]  chg_s, chg_w, dir_s, dir_w;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q_s[$];
  exp_t q_w[$];
  int   m_cnt[2][3];
  bit   m_dir[2][3];

  pmod_enc_array #(
    .CHANNELS(3), .WIDTH(8), .MAX(160), .FACTOR(0), .WRAP(0), .DEBOUNCE(4)
  ) dut_sat (
    .clk(clk), .rst(rst_s), .enc_a(a_s), .enc_b(b_s), .enc_btn(btn_s),
    .count(cnt_s), .changed(chg_s), .dir(dir_s)
  );

  pmod_enc_array #(
    .CHANNELS(3), .WIDTH(8), .MAX(256), .FACTOR(1), .WRAP(1), .DEBOUNCE(4)
  ) dut_wrap (
    .clk(clk), .rst(rst_w), .enc_a(a_w), .enc_b(b_w), .enc_btn(btn_w),
    .count(cnt_w), .changed(chg_w), .dir(dir_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference step arithmetic, written directly from the counting rules.
  function automatic int ref_next(input int c, input bit up, input int s, input int m, input bit wrap);
    if (up) return (c + s <= m - 1) ? c + s : (wrap ? c + s - m : m - 1);
    return (c >= s) ? c - s : (wrap ? c + m - s : 0);
  endfunction

  task automatic push_exp(input bit w, input int ch, input int c);
    exp_t e;
    e.ch  = ch;
    e.cnt = m_cnt[w][ch];
    e.dir = m_dir[w][ch];
    e.due = c + LAT;
    if (w) q_w.push_back(e);
    else   q_s.push_back(e);
  endtask

  // One clean detent: B settles first, then A is high 4 cycles and low 4 cycles.
  task automatic step(input bit w, input int ch, input bit up);
    int c, nv;
    if (w) begin
      if (b_w[ch] != !up) begin b_w[ch] = !up; wait_cyc(8); end
      a_w[ch] = 1'b1;
    end else begin
      if (b_s[ch] != !up) begin b_s[ch] = !up; wait_cyc(8); end
      a_s[ch] = 1'b1;
    end
    c  = cyc;
    nv = ref_next(m_cnt[w][ch], up, w ? 2 : 1, w ? 256 : 160, w);
    m_dir[w][ch] = up;
    if (nv != m_cnt[w][ch]) begin
      m_cnt[w][ch] = nv;
      push_exp(w, ch, c);
    end
    wait_cyc(4);
    if (w) a_w[ch] = 1'b0;
    else   a_s[ch] = 1'b0;
    wait_cyc(4);
  endtask

  task automatic mon(input bit w, input int ch, input int act, input bit d);
    exp_t e;
    string tag;
    tag = $sformatf("%s_ch%0d", w ? "wrap" : "sat", ch);
    if ((w && q_w.size() == 0) || (!w && q_s.size() == 0)) begin
      check(1'b0, {tag, "_unexpected_changed"}, act, -1);
    end else begin
      e = w ? q_w.pop_front() : q_s.pop_front();
      check(e.ch == ch,  {tag, "_channel"}, ch, e.ch);
      check(e.cnt == act, {tag, "_count"}, act, e.cnt);
      check(e.dir == d,  {tag, "_dir"}, int'(d), int'(e.dir));
      check(e.due == cyc, {tag, "_latency"}, cyc, e.due);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (chg_s[i]) mon(1'b0, i, int'(cnt_s[i*8 +: 8]), dir_s[i]);
      if (chg_w[i]) mon(1'b1, i, int'(cnt_w[i*8 +: 8]), dir_w[i]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 3; i++) begin
        m_cnt[w][i] = 0;
        m_dir[w][i] = 1'b1;
      end

    // Reset and idle
    wait_cyc(2);
    rst_s = 1'b0;
    rst_w = 1'b0;
    wait_cyc(100);
    for (int i = 0; i < 3; i++) begin
      check(cnt_s[i*8 +: 8] == 8'd0, $sformatf("idle_sat_count%0d", i), int'(cnt_s[i*8 +: 8]), 0);
      check(dir_s[i] == 1'b1,        $sformatf("idle_sat_dir%0d", i), int'(dir_s[i]), 1);
      check(cnt_w[i*8 +: 8] == 8'd0, $sformatf("idle_wrap_count%0d", i), int'(cnt_w[i*8 +: 8]), 0);
      check(dir_w[i] == 1'b1,        $sformatf("idle_wrap_dir%0d", i), int'(dir_w[i]), 1);
    end

    // Saturating up count: 165 detents, 159 counted
    for (int k = 0; k < 165; k++) step(1'b0, 0, 1'b1);
    check(cnt_s[7:0] == 8'd159, "sat_up_final", int'(cnt_s[7:0]), 159);
    check(cnt_s[15:8] == 8'd0,  "sat_up_ch1_idle", int'(cnt_s[15:8]), 0);
    check(cnt_s[23:16] == 8'd0, "sat_up_ch2_idle", int'(cnt_s[23:16]), 0);

    // Glitch rejection on channel 2: 3-cycle pulses ignored, a 4-cycle one counts
    for (int k = 0; k < 3; k++) begin
      a_s[2] = 1'b1;
      wait_cyc(3);
      a_s[2] = 1'b0;
      wait_cyc(6);
    end
    check(cnt_s[23:16] == 8'd0, "glitch_rejected", int'(cnt_s[23:16]), 0);
    step(1'b0, 2, 1'b1);
    check(cnt_s[23:16] == 8'd1, "glitch_4cycle_step", int'(cnt_s[23:16]), 1);

    // Clear priority on channel 1: count 37, then BTN and a down detent together
    for (int k = 0; k < 37; k++) step(1'b0, 1, 1'b1);
    check(cnt_s[15:8] == 8'd37, "clear_pre_count", int'(cnt_s[15:8]), 37);
    b_s[1] = 1'b1;
    wait_cyc(8);
    c = cyc;
    a_s[1]   = 1'b1;
    btn_s[1] = 1'b1;
    m_cnt[0][1] = 0;
    push_exp(1'b0, 1, c);
    wait_cyc(4);
    a_s[1]   = 1'b0;
    btn_s[1] = 1'b0;
    wait_cyc(8);
    check(cnt_s[15:8] == 8'd0, "clear_count", int'(cnt_s[15:8]), 0);
    check(dir_s[1] == 1'b1,    "clear_dir_kept", int'(dir_s[1]), 1);

    // Wrap mode, step 2: 0 down -> 254, then up -> 0, then up -> 2
    step(1'b1, 0, 1'b0);
    check(cnt_w[7:0] == 8'd254, "wrap_down_count", int'(cnt_w[7:0]), 254);
    check(dir_w[0] == 1'b0,     "wrap_down_dir", int'(dir_w[0]), 0);
    step(1'b1, 0, 1'b1);
    check(cnt_w[7:0] == 8'd0, "wrap_up_count", int'(cnt_w[7:0]), 0);
    check(dir_w[0] == 1'b1,   "wrap_up_dir", int'(dir_w[0]), 1);
    step(1'b1, 0, 1'b1);
    check(cnt_w[7:0] == 8'd2, "wrap_up2_count", int'(cnt_w[7:0]), 2);

    // Reset lands on the edge where a pending step would have been registered
    a_w[0] = 1'b1;
    wait_cyc(4);
    a_w[0] = 1'b0;
    wait_cyc(2);
    rst_w = 1'b1;
    wait_cyc(1);
    m_cnt[1][0] = 0;
    m_dir[1][0] = 1'b1;
    check(cnt_w[7:0] == 8'd0, "midrst_count", int'(cnt_w[7:0]), 0);
    check(chg_w[0] == 1'b0,   "midrst_changed", int'(chg_w[0]), 0);
    wait_cyc(1);
    rst_w = 1'b0;
    wait_cyc(30);
    check(cnt_w[7:0] == 8'd0, "midrst_after_count", int'(cnt_w[7:0]), 0);
    check(dir_w[0] == 1'b1,   "midrst_after_dir", int'(dir_w[0]), 1);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && (q_s.size() != 0 || q_w.size() != 0); k++) wait_cyc(1);
    check(q_s.size() == 0, "sat_pending_expected", q_s.size(), 0);
    check(q_w.size() == 0, "wrap_pending_expected", q_w.size(), 0);

    check(cnt_s == {8'd1, 8'd0, 8'd159}, "sat_final_bus", int'(cnt_s), 32'h01009F);
    check(dir_s == 3'b111, "sat_final_dir", int'(dir_s), 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
